// File: rtl/deck_controller_if.sv
// Bundle of game-side request/grant signals and the card RAM port of deck_controller.
// The slave modport is the controller; the master modport is game control plus the RAM.
interface deck_controller_if #(
    parameter int ADDR_W = 6
);
    logic              shuffle_req;
    logic              req_p;
    logic              req_d;
    logic              gnt_p;
    logic              gnt_d;
    logic              card_valid;
    logic [3:0]        card_value;
    logic              card_to;
    logic              shuffle_ok;
    logic [ADDR_W-1:0] cards_left;
    logic              low_deck;
    logic              deck_empty;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [3:0]        mem_wdata;
    logic [3:0]        mem_rdata;

    modport slave (
        input  shuffle_req, req_p, req_d, mem_rdata,
        output gnt_p, gnt_d, card_valid, card_value, card_to, shuffle_ok,
               cards_left, low_deck, deck_empty, mem_addr, mem_wr, mem_wdata
    );

    modport master (
        output shuffle_req, req_p, req_d, mem_rdata,
        input  gnt_p, gnt_d, card_valid, card_value, card_to, shuffle_ok,
               cards_left, low_deck, deck_empty, mem_addr, mem_wr, mem_wdata
    );
endinterface

// File: rtl/deck_controller.sv
// Card deck owner: fills the card RAM, Fisher-Yates shuffles it in place from an LFSR,
// then deals cards to the player and dealer paths with round-robin arbitration.
module deck_controller #(
    parameter int          DECK_SIZE    = 52,
    parameter int          ADDR_W       = 6,
    parameter int          RESHUFFLE_AT = 12,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    deck_controller_if.slave  bus,
    output logic [3:0]        o_dbg_state
);
    // Handshake: req_p/req_d are levels held until the matching gnt; the grant is a
    // one-cycle pulse in READY, the card follows as a one-cycle card_valid strobe two
    // cycles later, with card_value/card_to valid only while card_valid is high.

    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DECK_SIZE - 1);
    localparam logic [ADDR_W-1:0] FULL     = ADDR_W'(DECK_SIZE);
    localparam logic [ADDR_W-1:0] LOW_MARK = ADDR_W'(RESHUFFLE_AT);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    typedef enum logic [3:0] {
        S_FILL, S_PICK, S_RD_I, S_RD_J, S_CAP, S_WR_I, S_WR_J, S_READY, S_DELIVER
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [15:0]       r_lfsr;
    logic [15:0]       w_lfsr_nxt;
    logic [ADDR_W-1:0] r_k, r_i, r_j, r_ptr, r_cards_left;
    logic [3:0]        r_rank;
    logic [3:0]        r_a, r_b;
    logic              r_rr, r_side;
    logic              r_shuffle_ok;
    logic              r_card_valid;
    logic [3:0]        r_card_value;
    logic              r_card_to;

    logic              w_grant, w_side;
    logic [ADDR_W-1:0] w_j_cand;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_mem_wr;
    logic [3:0]        w_mem_wdata;
    logic [3:0]        w_rank_val;

    assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_j_cand   = r_lfsr[ADDR_W-1:0];

    always_comb begin
        w_rank_val = 4'd10;
        if (r_rank == 4'd0)
            w_rank_val = 4'd11;
        else if (r_rank <= 4'd9)
            w_rank_val = r_rank + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_FILL;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_side      = r_rr;
        w_mem_addr  = '0;
        w_mem_wr    = 1'b0;
        w_mem_wdata = 4'd0;
        case (r_state)
            S_FILL: begin
                w_mem_addr  = r_k;
                w_mem_wr    = 1'b1;
                w_mem_wdata = w_rank_val;
                if (r_k == LAST)
                    w_state_nxt = S_PICK;
            end
            // Out-of-range candidates are rejected rather than folded, keeping j uniform.
            S_PICK: if (w_j_cand <= r_i) w_state_nxt = S_RD_I;
            S_RD_I: begin
                w_mem_addr  = r_i;
                w_state_nxt = S_RD_J;
            end
            S_RD_J: begin
                w_mem_addr  = r_j;
                w_state_nxt = S_CAP;
            end
            S_CAP:  w_state_nxt = S_WR_I;
            S_WR_I: begin
                w_mem_addr  = r_i;
                w_mem_wr    = 1'b1;
                w_mem_wdata = r_b;
                w_state_nxt = S_WR_J;
            end
            S_WR_J: begin
                w_mem_addr  = r_j;
                w_mem_wr    = 1'b1;
                w_mem_wdata = r_a;
                w_state_nxt = (r_i == ONE) ? S_READY : S_PICK;
            end
            S_READY: begin
                w_mem_addr = r_ptr;
                if (bus.shuffle_req)
                    w_state_nxt = S_PICK;
                else if (r_cards_left != '0 && (bus.req_p || bus.req_d)) begin
                    w_grant     = 1'b1;
                    w_side      = (bus.req_p && bus.req_d) ? r_rr : bus.req_d;
                    w_state_nxt = S_DELIVER;
                end
            end
            S_DELIVER: w_state_nxt = S_READY;
            default:   w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr       <= LFSR_SEED;
            r_k          <= '0;
            r_rank       <= 4'd0;
            r_i          <= '0;
            r_j          <= '0;
            r_ptr        <= '0;
            r_cards_left <= '0;
            r_a          <= 4'd0;
            r_b          <= 4'd0;
            r_rr         <= 1'b0;
            r_side       <= 1'b0;
            r_shuffle_ok <= 1'b0;
            r_card_valid <= 1'b0;
            r_card_value <= 4'd0;
            r_card_to    <= 1'b0;
        end else begin
            r_lfsr       <= w_lfsr_nxt;
            r_card_valid <= 1'b0;
            case (r_state)
                S_FILL: begin
                    r_k    <= r_k + ONE;
                    r_rank <= (r_rank == 4'd12) ? 4'd0 : r_rank + 4'd1;
                    if (r_k == LAST)
                        r_i <= LAST;
                end
                S_PICK: if (w_j_cand <= r_i) r_j <= w_j_cand;
                S_RD_J: r_a <= bus.mem_rdata;
                S_CAP:  r_b <= bus.mem_rdata;
                S_WR_J: begin
                    if (r_i == ONE) begin
                        r_ptr        <= '0;
                        r_cards_left <= FULL;
                        r_shuffle_ok <= 1'b1;
                    end else
                        r_i <= r_i - ONE;
                end
                S_READY: begin
                    if (bus.shuffle_req) begin
                        r_shuffle_ok <= 1'b0;
                        r_i          <= LAST;
                    end else if (w_grant) begin
                        r_side <= w_side;
                        r_rr   <= ~w_side;
                    end
                end
                S_DELIVER: begin
                    r_card_valid <= 1'b1;
                    r_card_value <= bus.mem_rdata;
                    r_card_to    <= r_side;
                    r_ptr        <= r_ptr + ONE;
                    r_cards_left <= r_cards_left - ONE;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt_p      = w_grant && !w_side;
    assign bus.gnt_d      = w_grant && w_side;
    assign bus.card_valid = r_card_valid;
    assign bus.card_value = r_card_value;
    assign bus.card_to    = r_card_to;
    assign bus.shuffle_ok = r_shuffle_ok;
    assign bus.cards_left = r_cards_left;
    // low_deck is qualified by shuffle_ok so that it reads 0 out of reset and while shuffling.
    assign bus.low_deck   = r_shuffle_ok && (r_cards_left <= LOW_MARK);
    assign bus.deck_empty = (r_state == S_READY) && (r_cards_left == '0);
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wr     = w_mem_wr && !reset;
    assign bus.mem_wdata  = w_mem_wdata;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_deck_controller.sv
// Directed bench for deck_controller: RAM model, fill/shuffle/deal/arbitration/reset scenarios.
module tb_deck_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    deck_controller_if #(.ADDR_W(6)) bus();
    logic [3:0] dbg_state;

    deck_controller dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // Card RAM: synchronous write, read data one cycle after the address.
    logic [3:0] ram [0:63];
    always @(posedge clk) begin
        if (bus.mem_wr)
            ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [3:0] deal_val [$];
    logic       deal_to [$];
    int         gnt_cyc [$];
    logic       gnt_side [$];
    logic       exp_q [$];
    int         both_gnt = 0;
    logic [3:0] fill_log [0:63];
    int         fill_cnt = 0;
    int         fill_seq_err = 0;
    logic [3:0] order1 [0:51];
    int         hist [0:15];

    always @(negedge clk) begin
        if (reset)
            fill_cnt = 0;
        else begin
            if (bus.mem_wr && fill_cnt < 52) begin
                if (bus.mem_addr != 6'(fill_cnt)) fill_seq_err++;
                fill_log[bus.mem_addr] = bus.mem_wdata;
                fill_cnt++;
            end
            if (bus.card_valid) begin
                deal_val.push_back(bus.card_value);
                deal_to.push_back(bus.card_to);
            end
            if (bus.gnt_p || bus.gnt_d) begin
                gnt_cyc.push_back(cyc);
                gnt_side.push_back(bus.gnt_d);
            end
            if (bus.gnt_p && bus.gnt_d) both_gnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic int exp_count(int v);
        if (v == 10) return 16;
        if ((v >= 2 && v <= 9) || v == 11) return 4;
        return 0;
    endfunction

    function automatic logic [3:0] rank_val(int k);
        int r;
        r = k % 13;
        if (r == 0) return 4'd11;
        if (r <= 9) return 4'(r + 1);
        return 4'd10;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        deal_val.delete();
        deal_to.delete();
        gnt_cyc.delete();
        gnt_side.delete();
        both_gnt = 0;
    endtask

    task automatic hold_req(input logic p, input logic d, input int n);
        bus.req_p = p;
        bus.req_d = d;
        step(n);
        bus.req_p = 1'b0;
        bus.req_d = 1'b0;
    endtask

    task automatic wait_ok(input int budget, output logic ok);
        int t;
        t = 0;
        while (!bus.shuffle_ok && t < budget) begin
            step(1);
            t++;
        end
        ok = bus.shuffle_ok;
    endtask

    task automatic hist_from_ram();
        for (int v = 0; v < 16; v++) hist[v] = 0;
        for (int k = 0; k < 52; k++) hist[ram[k]]++;
    endtask

    task automatic hist_from_deal();
        for (int v = 0; v < 16; v++) hist[v] = 0;
        foreach (deal_val[k]) hist[deal_val[k]]++;
    endtask

    task automatic test_reset_fill();
        logic ok;
        reset = 1'b1;
        step(3);
        n_cmp++; if (bus.shuffle_ok !== 1'b0) begin n_err++; $display("FAIL reset_shuffle_ok: got %b want 0", bus.shuffle_ok); end
        n_cmp++; if (bus.cards_left !== 6'd0) begin n_err++; $display("FAIL reset_cards_left: got %0d want 0", bus.cards_left); end
        n_cmp++; if ({bus.gnt_p, bus.gnt_d, bus.card_valid} !== 3'b000) begin n_err++; $display("FAIL reset_strobes: got %b want 000", {bus.gnt_p, bus.gnt_d, bus.card_valid}); end
        n_cmp++; if ({bus.mem_wr, bus.low_deck, bus.deck_empty} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {bus.mem_wr, bus.low_deck, bus.deck_empty}); end
        reset = 1'b0;
        wait_ok(5000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL first_shuffle_done: got %b want 1", ok); end
        n_cmp++; if (fill_cnt != 52 || fill_seq_err != 0) begin n_err++; $display("FAIL fill_sequence: got %0d writes %0d out of order, want 52 and 0", fill_cnt, fill_seq_err); end
        n_cmp++; if (fill_log[0] !== 4'd11) begin n_err++; $display("FAIL fill_addr0: got %0d want 11", fill_log[0]); end
        n_cmp++; if (fill_log[1] !== 4'd2) begin n_err++; $display("FAIL fill_addr1: got %0d want 2", fill_log[1]); end
        n_cmp++; if (fill_log[9] !== 4'd10) begin n_err++; $display("FAIL fill_addr9: got %0d want 10", fill_log[9]); end
        n_cmp++; if (fill_log[12] !== 4'd10) begin n_err++; $display("FAIL fill_addr12: got %0d want 10", fill_log[12]); end
        n_cmp++; if (fill_log[13] !== 4'd11) begin n_err++; $display("FAIL fill_addr13: got %0d want 11", fill_log[13]); end
        n_cmp++; if (fill_log[51] !== 4'd10) begin n_err++; $display("FAIL fill_addr51: got %0d want 10", fill_log[51]); end
        n_cmp++; if (bus.cards_left !== 6'd52) begin n_err++; $display("FAIL ready_cards_left: got %0d want 52", bus.cards_left); end
        n_cmp++; if ({bus.low_deck, bus.deck_empty} !== 2'b00) begin n_err++; $display("FAIL ready_flags: got %b want 00", {bus.low_deck, bus.deck_empty}); end
        hist_from_ram();
        for (int v = 0; v < 16; v++) begin
            n_cmp++; if (hist[v] != exp_count(v)) begin n_err++; $display("FAIL ram_perm_after_fill value %0d: got %0d want %0d", v, hist[v], exp_count(v)); end
        end
    endtask

    task automatic test_deal_all();
        int ones, same;
        clear_logs();
        hold_req(1'b1, 1'b0, 104);
        step(3);
        n_cmp++; if (deal_val.size() != 52) begin n_err++; $display("FAIL deal_all_count: got %0d want 52", deal_val.size()); end
        hist_from_deal();
        for (int v = 0; v < 16; v++) begin
            n_cmp++; if (hist[v] != exp_count(v)) begin n_err++; $display("FAIL deal_multiset value %0d: got %0d want %0d", v, hist[v], exp_count(v)); end
        end
        ones = 0;
        same = 0;
        foreach (deal_to[k]) if (deal_to[k] !== 1'b0) ones++;
        for (int k = 0; k < 52 && k < deal_val.size(); k++) begin
            order1[k] = deal_val[k];
            if (deal_val[k] == rank_val(k)) same++;
        end
        n_cmp++; if (ones != 0) begin n_err++; $display("FAIL deal_all_card_to: got %0d dealer cards want 0", ones); end
        n_cmp++; if (same == 52) begin n_err++; $display("FAIL deal_shuffled: got %0d positions in fill order want fewer than 52", same); end
        n_cmp++; if (bus.cards_left !== 6'd0 || bus.deck_empty !== 1'b1) begin n_err++; $display("FAIL deal_all_empty: got left=%0d empty=%b want 0 and 1", bus.cards_left, bus.deck_empty); end
        n_cmp++; if (bus.low_deck !== 1'b1) begin n_err++; $display("FAIL deal_all_low: got %b want 1", bus.low_deck); end
        hist_from_ram();
        for (int v = 0; v < 16; v++) begin
            n_cmp++; if (hist[v] != exp_count(v)) begin n_err++; $display("FAIL ram_perm_after_deal value %0d: got %0d want %0d", v, hist[v], exp_count(v)); end
        end
    endtask

    task automatic test_shuffle_req();
        logic ok;
        clear_logs();
        bus.shuffle_req = 1'b1;
        step(1);
        bus.shuffle_req = 1'b0;
        n_cmp++; if (bus.shuffle_ok !== 1'b0) begin n_err++; $display("FAIL reshuffle_start: got %b want 0", bus.shuffle_ok); end
        step(20);
        bus.shuffle_req = 1'b1;
        step(1);
        bus.shuffle_req = 1'b0;
        n_cmp++; if (bus.shuffle_ok !== 1'b0) begin n_err++; $display("FAIL reshuffle_ignored_req: got %b want 0", bus.shuffle_ok); end
        wait_ok(5000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL reshuffle_done: got %b want 1", ok); end
        n_cmp++; if (bus.cards_left !== 6'd52 || bus.deck_empty !== 1'b0) begin n_err++; $display("FAIL reshuffle_left: got left=%0d empty=%b want 52 and 0", bus.cards_left, bus.deck_empty); end
        n_cmp++; if (deal_val.size() != 0) begin n_err++; $display("FAIL reshuffle_no_cards: got %0d strobes want 0", deal_val.size()); end
        hist_from_ram();
        for (int v = 0; v < 16; v++) begin
            n_cmp++; if (hist[v] != exp_count(v)) begin n_err++; $display("FAIL ram_perm_after_reshuffle value %0d: got %0d want %0d", v, hist[v], exp_count(v)); end
        end
    endtask

    // The preceding deal granted only the player, leaving round-robin pointing at the dealer.
    task automatic test_alternate();
        logic e;
        clear_logs();
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back((k % 2) == 0);
        hold_req(1'b1, 1'b1, 16);
        step(3);
        n_cmp++; if (gnt_side.size() != 8) begin n_err++; $display("FAIL alt_grant_count: got %0d want 8", gnt_side.size()); end
        n_cmp++; if (deal_to.size() != 8) begin n_err++; $display("FAIL alt_card_count: got %0d want 8", deal_to.size()); end
        n_cmp++; if (both_gnt != 0) begin n_err++; $display("FAIL alt_double_grant: got %0d want 0", both_gnt); end
        for (int k = 0; k < 8 && k < gnt_side.size() && k < deal_to.size(); k++) begin
            e = exp_q.pop_front();
            n_cmp++; if (gnt_side[k] !== e) begin n_err++; $display("FAIL alt_grant_side %0d: got %b want %b", k, gnt_side[k], e); end
            n_cmp++; if (deal_to[k] !== e) begin n_err++; $display("FAIL alt_card_to %0d: got %b want %b", k, deal_to[k], e); end
            if (k > 0) begin
                n_cmp++; if (gnt_cyc[k] - gnt_cyc[k-1] != 2) begin n_err++; $display("FAIL alt_grant_gap %0d: got %0d want 2", k, gnt_cyc[k] - gnt_cyc[k-1]); end
            end
        end
        n_cmp++; if (bus.cards_left !== 6'd44) begin n_err++; $display("FAIL alt_cards_left: got %0d want 44", bus.cards_left); end
    endtask

    task automatic test_low_deck();
        clear_logs();
        hold_req(1'b1, 1'b0, 62);
        step(2);
        n_cmp++; if (deal_val.size() != 31) begin n_err++; $display("FAIL low_count31: got %0d want 31", deal_val.size()); end
        n_cmp++; if (bus.cards_left !== 6'd13 || bus.low_deck !== 1'b0) begin n_err++; $display("FAIL low_at13: got left=%0d low=%b want 13 and 0", bus.cards_left, bus.low_deck); end
        hold_req(1'b1, 1'b0, 2);
        step(2);
        n_cmp++; if (bus.cards_left !== 6'd12 || bus.low_deck !== 1'b1) begin n_err++; $display("FAIL low_at12: got left=%0d low=%b want 12 and 1", bus.cards_left, bus.low_deck); end
        hold_req(1'b1, 1'b0, 24);
        step(2);
        n_cmp++; if (bus.cards_left !== 6'd0 || bus.deck_empty !== 1'b1) begin n_err++; $display("FAIL low_empty: got left=%0d empty=%b want 0 and 1", bus.cards_left, bus.deck_empty); end
        clear_logs();
        hold_req(1'b0, 1'b1, 20);
        step(2);
        n_cmp++; if (gnt_side.size() != 0 || deal_val.size() != 0) begin n_err++; $display("FAIL empty_no_grant: got %0d grants %0d cards want 0 and 0", gnt_side.size(), deal_val.size()); end
    endtask

    task automatic test_reset_mid();
        logic ok;
        int diff;
        bus.shuffle_req = 1'b1;
        step(1);
        bus.shuffle_req = 1'b0;
        step(60);
        reset = 1'b1;
        #1;
        n_cmp++; if ({bus.shuffle_ok, bus.mem_wr, bus.low_deck, bus.deck_empty} !== 4'b0000) begin n_err++; $display("FAIL midshuffle_reset_flags: got %b want 0000", {bus.shuffle_ok, bus.mem_wr, bus.low_deck, bus.deck_empty}); end
        n_cmp++; if (bus.cards_left !== 6'd0) begin n_err++; $display("FAIL midshuffle_reset_left: got %0d want 0", bus.cards_left); end
        step(2);
        reset = 1'b0;
        wait_ok(5000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL refill_shuffle_done: got %b want 1", ok); end
        n_cmp++; if (fill_cnt != 52 || fill_seq_err != 0 || fill_log[0] !== 4'd11) begin n_err++; $display("FAIL refill_sequence: got %0d writes %0d bad addr0=%0d want 52 0 11", fill_cnt, fill_seq_err, fill_log[0]); end
        bus.req_p = 1'b1;
        #1;
        n_cmp++; if (bus.gnt_p !== 1'b1) begin n_err++; $display("FAIL grant_before_reset: got %b want 1", bus.gnt_p); end
        reset = 1'b1;
        #1;
        bus.req_p = 1'b0;
        n_cmp++; if ({bus.gnt_p, bus.card_valid, bus.shuffle_ok} !== 3'b000) begin n_err++; $display("FAIL grant_reset_outputs: got %b want 000", {bus.gnt_p, bus.card_valid, bus.shuffle_ok}); end
        clear_logs();
        step(3);
        reset = 1'b0;
        step(3);
        n_cmp++; if (deal_val.size() != 0) begin n_err++; $display("FAIL lost_grant_no_card: got %0d strobes want 0", deal_val.size()); end
        wait_ok(5000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL post_reset_shuffle_done: got %b want 1", ok); end
        clear_logs();
        hold_req(1'b1, 1'b0, 104);
        step(3);
        n_cmp++; if (deal_val.size() != 52) begin n_err++; $display("FAIL replay_count: got %0d want 52", deal_val.size()); end
        diff = 0;
        for (int k = 0; k < 52 && k < deal_val.size(); k++) if (deal_val[k] !== order1[k]) diff++;
        n_cmp++; if (diff != 0) begin n_err++; $display("FAIL replay_order: got %0d differing positions want 0", diff); end
    endtask

    initial begin
        bus.shuffle_req = 1'b0;
        bus.req_p       = 1'b0;
        bus.req_d       = 1'b0;
        test_reset_fill();
        test_deal_all();
        test_shuffle_req();
        test_alternate();
        test_low_deck();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
